mac_frame_gen_chk: RTL

MAC_FRAME_GEN_CHK -- requirements
Module: mac_frame_gen_chk

---
 rtl/mac_frame_gen_chk_pkg.sv | 28 ++
 rtl/mac_frame_gen_chk_chk.sv | 83 ++++++++
 rtl/mac_frame_gen_chk.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mac_frame_gen_chk_pkg.sv
// Shared definitions for the MAC loopback frame generator/checker:
// AXIS widths, TX FSM state encoding and the per-beat test pattern.
package mac_frame_gen_chk_pkg;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam int unsigned AXIS_KEEP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_GAP,
        ST_FIN
    } tx_state_t;

    // Beat k of frame f: {f, k, ~f, ~k}, 16 bits each
    function automatic logic [AXIS_DATA_W-1:0] frame_pattern(
        input logic [15:0] f,
        input logic [15:0] k
    );
        return {f, k, ~f, ~k};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac_frame_gen_chk_chk.sv
// RX checker: tracks its own frame/beat index, compares every beat against
// the expected pattern and counts received and bad frames.
module mac_frame_chk
    import mac_frame_gen_chk_pkg::*;
#(
    parameter int unsigned FRAME_BEATS = 8
) (
    input  logic                   i_clk,
    input  logic                   i_sys_reset,
    input  logic                   i_enable,
    input  logic                   i_clear,
    input  logic [AXIS_DATA_W-1:0] i_rx_tdata,
    input  logic [AXIS_KEEP_W-1:0] i_rx_tkeep,
    input  logic                   i_rx_tvalid,
    input  logic                   i_rx_tlast,
    input  logic                   i_rx_tuser,
    output logic [15:0]            o_rx_frame_cnt,
    output logic [15:0]            o_err_cnt
);

    localparam logic [15:0] LAST_BEAT = 16'(FRAME_BEATS - 1);

    logic [15:0] r_beat;
    logic [15:0] r_frame;
    logic        r_bad;
    logic        r_resync;
    logic [15:0] r_rx_cnt;
    logic [15:0] r_err_cnt;

    logic        w_last;
    logic        w_mismatch;
    logic        w_bad;

    always_comb begin
        w_last     = (r_beat == LAST_BEAT);
        w_mismatch = (i_rx_tdata != frame_pattern(r_frame, r_beat))
                   || (i_rx_tkeep != '1)
                   || (i_rx_tlast && i_rx_tuser)
                   || (i_rx_tlast != w_last);
        w_bad      = r_bad | w_mismatch;
    end

    // A frame that overruns without tlast is charged once at its last beat;
    // everything up to the next tlast is then skipped as a lost frame.
    always_ff @(posedge i_clk) begin
        if (i_sys_reset || i_clear) begin
            r_beat    <= '0;
            r_frame   <= '0;
            r_bad     <= 1'b0;
            r_resync  <= 1'b0;
            r_rx_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (i_enable && i_rx_tvalid) begin
            if (r_resync) begin
                if (i_rx_tlast) begin
                    r_resync <= 1'b0;
                    r_frame  <= r_frame + 16'd1;
                    r_beat   <= '0;
                    r_rx_cnt <= sat_inc16(r_rx_cnt);
                end
            end else if (i_rx_tlast || w_last) begin
                if (w_bad) begin
                    r_err_cnt <= sat_inc16(r_err_cnt);
                end
                r_bad   <= 1'b0;
                r_beat  <= '0;
                r_frame <= r_frame + 16'd1;
                if (i_rx_tlast) begin
                    r_rx_cnt <= sat_inc16(r_rx_cnt);
                end else begin
                    r_resync <= 1'b1;
                end
            end else begin
                r_beat <= r_beat + 16'd1;
                r_bad  <= w_bad;
            end
        end
    end

    assign o_rx_frame_cnt = r_rx_cnt;
    assign o_err_cnt      = r_err_cnt;

endmodule

// File: rtl/mac_frame_gen_chk.sv
// MAC loopback test engine: TX frame generator FSM plus the RX checker,
// with run control, timeout and pass/fail status.
module mac_frame_gen_chk
    import mac_frame_gen_chk_pkg::*;
#(
    parameter int unsigned NR_FRAMES   = 16,
    parameter int unsigned FRAME_BEATS = 8,
    parameter int unsigned IFG_CYCLES  = 4,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   sys_reset,
    input  logic                   mac_ready,
    input  logic                   start,
    output logic [AXIS_DATA_W-1:0] tx_tdata,
    output logic [AXIS_KEEP_W-1:0] tx_tkeep,
    output logic                   tx_tvalid,
    output logic                   tx_tlast,
    input  logic                   tx_tready,
    input  logic [AXIS_DATA_W-1:0] rx_tdata,
    input  logic [AXIS_KEEP_W-1:0] rx_tkeep,
    input  logic                   rx_tvalid,
    input  logic                   rx_tlast,
    input  logic                   rx_tuser,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            tx_frame_cnt,
    output logic [15:0]            rx_frame_cnt,
    output logic [15:0]            err_cnt
);

    localparam logic [15:0] LAST_BEAT = 16'(FRAME_BEATS - 1);
    localparam logic [15:0] NR_CNT    = 16'(NR_FRAMES);
    localparam logic [7:0]  GAP_LAST  = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

    tx_state_t   r_state;
    tx_state_t   w_next;

    logic [15:0] r_tx_cnt;
    logic [15:0] r_beat;
    logic [7:0]  r_gap;
    logic [31:0] r_to;
    logic        r_done;
    logic        r_pass;

    logic        w_busy;
    logic        w_start_ok;
    logic        w_last_beat;
    logic        w_tx_hs;
    logic [15:0] w_rx_frame_cnt;
    logic [15:0] w_err_cnt;

    assign w_busy      = (r_state != ST_IDLE) && !r_done;
    assign w_start_ok  = start && !w_busy;
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_tx_hs     = (r_state == ST_SEND) && tx_tready;

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        tx_tvalid = 1'b0;
        tx_tlast  = 1'b0;
        tx_tdata  = '0;
        tx_tkeep  = '0;
        unique case (r_state)
            ST_IDLE:     if (w_start_ok) w_next = ST_WAIT_RDY;
            ST_WAIT_RDY: if (mac_ready) w_next = ST_SEND;
            ST_SEND: begin
                tx_tvalid = 1'b1;
                tx_tlast  = w_last_beat;
                tx_tdata  = frame_pattern(r_tx_cnt, r_beat);
                tx_tkeep  = '1;
                if (tx_tready && w_last_beat) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_next = (r_tx_cnt == NR_CNT) ? ST_FIN : ST_WAIT_RDY;
                end
            end
            ST_FIN:      if (w_start_ok) w_next = ST_WAIT_RDY;
            default:     w_next = ST_IDLE;
        endcase
    end

    // The TX frame index is the sent-frame count itself, so the pattern
    // stays aligned with tx_frame_cnt across every stall.
    always_ff @(posedge clk) begin
        if (sys_reset || w_start_ok) begin
            r_tx_cnt <= '0;
            r_beat   <= '0;
            r_gap    <= '0;
            r_to     <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            if (w_tx_hs) begin
                if (w_last_beat) begin
                    r_beat   <= '0;
                    r_gap    <= '0;
                    r_tx_cnt <= sat_inc16(r_tx_cnt);
                end else begin
                    r_beat <= r_beat + 16'd1;
                end
            end
            if (r_state == ST_GAP) begin
                r_gap <= r_gap + 8'd1;
            end
            if ((r_state == ST_FIN) && !r_done) begin
                if (w_rx_frame_cnt == NR_CNT) begin
                    r_done <= 1'b1;
                    r_pass <= (w_err_cnt == '0);
                end else if (rx_tvalid) begin
                    r_to <= '0;
                end else if (r_to == TO_LAST) begin
                    r_done <= 1'b1;
                    r_pass <= 1'b0;
                end else begin
                    r_to <= r_to + 32'd1;
                end
            end
        end
    end

    mac_frame_chk #(
        .FRAME_BEATS (FRAME_BEATS)
    ) u_chk (
        .i_clk          (clk),
        .i_sys_reset    (sys_reset),
        .i_enable       (r_state != ST_IDLE),
        .i_clear        (w_start_ok),
        .i_rx_tdata     (rx_tdata),
        .i_rx_tkeep     (rx_tkeep),
        .i_rx_tvalid    (rx_tvalid),
        .i_rx_tlast     (rx_tlast),
        .i_rx_tuser     (rx_tuser),
        .o_rx_frame_cnt (w_rx_frame_cnt),
        .o_err_cnt      (w_err_cnt)
    );

    assign busy         = w_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign tx_frame_cnt = r_tx_cnt;
    assign rx_frame_cnt = w_rx_frame_cnt;
    assign err_cnt      = w_err_cnt;

endmodule
